// File: rtl/pagerank_pkg.sv
// ============================================================================
//  Module      : pagerank_pkg
//  Description : Shared types and fixed-point constants for the PageRank
//                node-update sequencer and its helpers.
//                  - state_t   : sequencer state encoding
//                  - C_BASE    : 1.0 in Q0.16 (17 bits wide)
//                  - C_D       : damping factor d (~0.15)
//                  - C_DN      : d/N for the default N=4
//                  - C_DB      : BASE-d, scale applied to each neighbour term
//                  - sat_inc8  : saturating 8-bit increment
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pagerank_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        ACC    = 3'd2,
        WR     = 3'd3,
        END_IT = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [16:0] C_BASE      = 17'h10000;
    localparam logic [15:0] C_D         = 16'h2666;
    localparam int          C_N_DEFAULT = 4;
    localparam logic [15:0] C_DN        = C_D / 16'(C_N_DEFAULT);
    localparam logic [15:0] C_DB        = 16'(C_BASE - {1'b0, C_D});

    // Iteration counter helper: sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pagerank_delta_max.sv
// ============================================================================
//  Module      : pagerank_delta_max
//  Description : Absolute difference of two unsigned values with a running
//                maximum. i_clr restarts the maximum at zero; i_en folds the
//                current |i_a - i_b| into it.
//  Ports       : clk, reset (async, active high)
//                i_clr, i_en        control
//                i_a, i_b [WIDTH]   operands
//                o_max   [WIDTH]    running maximum
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pagerank_delta_max #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_max
);

    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] r_max;

    assign w_diff = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);
    assign o_max  = r_max;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_max <= '0;
        end else if (i_clr) begin
            r_max <= '0;
        end else if (i_en && (w_diff > r_max)) begin
            r_max <= w_diff;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pagerank_iter_ctrl.sv
// ============================================================================
//  Module      : pagerank_iter_ctrl
//  Description : Sequencer for the PageRank node-update datapath. Walks every
//                page (CLR, one ACC per column, WR) on a shared MAC, repeats
//                for up to MAX_ITER iterations and reports via done.
//                Optional macro PAGERANK_CONVERGE_EN adds early stop when the
//                largest per-node change of an iteration is below EPS.
//  Ports       : clk, reset (async, active high), start
//                adj_row [N]      adjacency row of page row_idx
//                acc_val, old_val datapath values, sampled in WR
//                busy, done, row_idx, col_idx, mac_clr, mac_en, wr_en,
//                iter_count [8], converged
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pagerank_iter_ctrl
    import pagerank_pkg::*;
#(
    parameter int               N        = 4,
    parameter int               IDX_W    = 2,
    parameter int               WIDTH    = 16,
    parameter int               MAX_ITER = 32,
    parameter logic [WIDTH-1:0] EPS      = 16'h0010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N-1:0]     adj_row,
    input  logic [WIDTH-1:0] acc_val,
    input  logic [WIDTH-1:0] old_val,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] row_idx,
    output logic [IDX_W-1:0] col_idx,
    output logic             mac_clr,
    output logic             mac_en,
    output logic             wr_en,
    output logic [7:0]       iter_count,
    output logic             converged
);

    state_t           r_state;
    logic [IDX_W-1:0] w_col_nxt;
    logic             w_last_col;
    logic             w_last_row;
    logic             w_last_iter;
    logic             w_early_stop;

    assign w_col_nxt   = col_idx + IDX_W'(1);
    assign w_last_col  = (col_idx == IDX_W'(N - 1));
    assign w_last_row  = (row_idx == IDX_W'(N - 1));
    assign w_last_iter = (iter_count == 8'(MAX_ITER - 1));

`ifdef PAGERANK_CONVERGE_EN
    logic [WIDTH-1:0] w_max_delta;
    logic             w_delta_clr;
    logic             w_delta_en;

    // The maximum restarts whenever a new iteration begins; END_IT reads the
    // finished value in the same cycle the clear is applied.
    assign w_delta_clr = ((r_state == IDLE) && start) || (r_state == END_IT);
    assign w_delta_en  = (r_state == WR);

    pagerank_delta_max #(
        .WIDTH (WIDTH)
    ) u_delta_max (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_delta_clr),
        .i_en  (w_delta_en),
        .i_a   (acc_val),
        .i_b   (old_val),
        .o_max (w_max_delta)
    );

    assign w_early_stop = (w_max_delta < EPS);
`else
    // Datapath values only matter for the convergence check.
    logic w_unused;
    assign w_unused     = ^{acc_val, old_val, EPS};
    assign w_early_stop = 1'b0;
`endif

    // Every output is registered: the value an output takes in a state is
    // loaded on the edge that enters that state. Node writes land before the
    // following CLR, so later rows in the same iteration see updated values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            row_idx    <= '0;
            col_idx    <= '0;
            mac_clr    <= 1'b0;
            mac_en     <= 1'b0;
            wr_en      <= 1'b0;
            iter_count <= 8'd0;
            converged  <= 1'b0;
        end else begin
            mac_clr <= 1'b0;
            mac_en  <= 1'b0;
            wr_en   <= 1'b0;
            done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        iter_count <= 8'd0;
                        converged  <= 1'b0;
                        row_idx    <= '0;
                        col_idx    <= '0;
                        busy       <= 1'b1;
                        mac_clr    <= 1'b1;
                        r_state    <= CLR;
                    end
                end
                CLR: begin
                    col_idx <= '0;
                    mac_en  <= adj_row[0];
                    r_state <= ACC;
                end
                ACC: begin
                    if (w_last_col) begin
                        wr_en   <= 1'b1;
                        r_state <= WR;
                    end else begin
                        col_idx <= w_col_nxt;
                        mac_en  <= adj_row[w_col_nxt];
                    end
                end
                WR: begin
                    col_idx <= '0;
                    if (w_last_row) begin
                        // END_IT is a bubble with busy low and indices cleared.
                        busy    <= 1'b0;
                        row_idx <= '0;
                        r_state <= END_IT;
                    end else begin
                        row_idx <= row_idx + IDX_W'(1);
                        mac_clr <= 1'b1;
                        r_state <= CLR;
                    end
                end
                END_IT: begin
                    iter_count <= sat_inc8(iter_count);
                    row_idx    <= '0;
                    if (w_last_iter || w_early_stop) begin
                        converged <= w_early_stop;
                        done      <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        busy    <= 1'b1;
                        mac_clr <= 1'b1;
                        r_state <= CLR;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
